// File: rtl/bicubic_interp_pkg.sv
// Shared constants for the 4x4 bicubic upscaler: widths, a=-0.5 coefficient
// table, rounding constant and output clamp bounds.
package bicubic_interp_pkg;

  localparam int PIX_W     = 24;
  localparam int COEF_W    = 12;
  localparam int FRAC_BITS = 10;
  localparam int SMP_W     = 9;
  localparam int H_W       = 21;
  localparam int ACC_W     = 32;

  // Row t holds the four tap weights for sub-pixel offset t; each row sums to 1024.
  localparam logic signed [COEF_W-1:0] COEF [4][4] = '{
    '{-12'sd49,  12'sd987,  12'sd93,  -12'sd7 },
    '{-12'sd75,  12'sd745,  12'sd399, -12'sd45},
    '{-12'sd45,  12'sd399,  12'sd745, -12'sd75},
    '{-12'sd7,   12'sd93,   12'sd987, -12'sd49}
  };

  localparam logic signed [ACC_W-1:0] RND_CONST = ACC_W'(1) << (2 * FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] CLAMP_MIN = '0;
  localparam logic signed [ACC_W-1:0] CLAMP_MAX = ACC_W'(255);

endpackage

// File: rtl/bicubic_interp_if.sv
// Window request and pixel response signals between the line buffer,
// the bicubic upscaler and the downstream consumer.
interface bicubic_interp_if;
  import bicubic_interp_pkg::*;

  logic             bf_req_valid;
  logic             bcci_req_ready;
  logic             bcci_2_bf_hsked;
  logic [PIX_W-1:0] in_p1,  in_p2,  in_p3,  in_p4;
  logic [PIX_W-1:0] in_p5,  in_p6,  in_p7,  in_p8;
  logic [PIX_W-1:0] in_p9,  in_p10, in_p11, in_p12;
  logic [PIX_W-1:0] in_p13, in_p14, in_p15, in_p16;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [PIX_W-1:0] rsp_data;
  logic [3:0]       rsp_phase;
  logic             rsp_tile_last;

  modport slave (
    input  bf_req_valid, rsp_ready,
    input  in_p1, in_p2, in_p3, in_p4, in_p5, in_p6, in_p7, in_p8,
    input  in_p9, in_p10, in_p11, in_p12, in_p13, in_p14, in_p15, in_p16,
    output bcci_req_ready, bcci_2_bf_hsked,
    output rsp_valid, rsp_data, rsp_phase, rsp_tile_last
  );

  modport master (
    output bf_req_valid, rsp_ready,
    output in_p1, in_p2, in_p3, in_p4, in_p5, in_p6, in_p7, in_p8,
    output in_p9, in_p10, in_p11, in_p12, in_p13, in_p14, in_p15, in_p16,
    input  bcci_req_ready, bcci_2_bf_hsked,
    input  rsp_valid, rsp_data, rsp_phase, rsp_tile_last
  );
endinterface

// File: rtl/bicubic_mac4.sv
// Combinational signed 4-tap dot product; OUT_W must hold the exact sum.
module bicubic_mac4
  import bicubic_interp_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 21
) (
  input  logic signed [IN_W-1:0]   smp  [4],
  input  logic signed [COEF_W-1:0] coef [4],
  output logic signed [OUT_W-1:0]  sum
);

  always_comb begin
    sum = '0;
    for (int j = 0; j < 4; j++) begin
      sum = sum + OUT_W'(smp[j]) * OUT_W'(coef[j]);
    end
  end

endmodule

// File: rtl/bicubic_interp.sv
// 4x bicubic upscaler for one 4x4 RGB window: one output pixel per accepted
// phase, three-stage pipeline (window capture, horizontal MAC, vertical MAC).
module bicubic_interp
  import bicubic_interp_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  bicubic_interp_if.slave bus
);

  function automatic logic [7:0] round_clamp(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] y;
    y = (acc + RND_CONST) >>> (2 * FRAC_BITS);
    if (y < CLAMP_MIN)      round_clamp = CLAMP_MIN[7:0];
    else if (y > CLAMP_MAX) round_clamp = CLAMP_MAX[7:0];
    else                    round_clamp = y[7:0];
  endfunction

  logic [3:0]               phase_cnt;
  logic                     vld_p0, vld_p1, vld_p2;
  logic                     ld_p0, ld_p1, ld_p2, hsk;
  logic [PIX_W-1:0]         win_in [16];
  logic [PIX_W-1:0]         win_p0 [16];
  logic [3:0]               k_p0, k_p1, rsp_phase_p2;
  logic signed [COEF_W-1:0] wx [4];
  logic signed [COEF_W-1:0] wy [4];
  logic signed [H_W-1:0]    h_s2 [3][4];
  logic signed [H_W-1:0]    h_p1 [3][4];
  logic signed [ACC_W-1:0]  acc_s3 [3];
  logic [PIX_W-1:0]         rsp_data_p2;

  assign win_in[0]  = bus.in_p1;   assign win_in[1]  = bus.in_p2;
  assign win_in[2]  = bus.in_p3;   assign win_in[3]  = bus.in_p4;
  assign win_in[4]  = bus.in_p5;   assign win_in[5]  = bus.in_p6;
  assign win_in[6]  = bus.in_p7;   assign win_in[7]  = bus.in_p8;
  assign win_in[8]  = bus.in_p9;   assign win_in[9]  = bus.in_p10;
  assign win_in[10] = bus.in_p11;  assign win_in[11] = bus.in_p12;
  assign win_in[12] = bus.in_p13;  assign win_in[13] = bus.in_p14;
  assign win_in[14] = bus.in_p15;  assign win_in[15] = bus.in_p16;

  // A stage loads when it is empty or its content moves on this cycle.
  assign ld_p2 = ~vld_p2 | bus.rsp_ready;
  assign ld_p1 = ~vld_p1 | ld_p2;
  assign ld_p0 = ~vld_p0 | ld_p1;
  assign hsk   = bus.bf_req_valid & ld_p0;

  assign bus.bcci_req_ready  = ld_p0;
  assign bus.bcci_2_bf_hsked = hsk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      if (hsk)   phase_cnt <= phase_cnt + 4'd1;
      if (ld_p0) vld_p0    <= bus.bf_req_valid;
      if (ld_p1) vld_p1    <= vld_p0;
      if (ld_p2) vld_p2    <= vld_p1;
    end
  end

  // Stage p0: window and phase capture
  always_ff @(posedge clk) begin
    if (hsk) begin
      win_p0 <= win_in;
      k_p0   <= phase_cnt;
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      wx[j] = COEF[k_p0[1:0]][j];
      wy[j] = COEF[k_p1[3:2]][j];
    end
  end

  // Channel c covers bits [8c+7:8c]: c=0 blue, c=1 green, c=2 red.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic signed [H_W-1:0] hv [4];
    for (genvar r = 0; r < 4; r++) begin : g_row
      logic signed [SMP_W-1:0] smp [4];
      for (genvar j = 0; j < 4; j++) begin : g_tap
        assign smp[j] = {1'b0, win_p0[4*r+j][8*c +: 8]};
      end
      assign hv[r] = h_p1[c][r];
      bicubic_mac4 #(.IN_W(SMP_W), .OUT_W(H_W)) u_mac_h (
        .smp  (smp),
        .coef (wx),
        .sum  (h_s2[c][r])
      );
    end
    bicubic_mac4 #(.IN_W(H_W), .OUT_W(ACC_W)) u_mac_v (
      .smp  (hv),
      .coef (wy),
      .sum  (acc_s3[c])
    );
  end

  // Stage p1: horizontal row sums
  always_ff @(posedge clk) begin
    if (ld_p1 && vld_p0) begin
      h_p1 <= h_s2;
      k_p1 <= k_p0;
    end
  end

  // Stage p2: vertical sum, rounded and clamped output pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_p2  <= '0;
      rsp_phase_p2 <= '0;
    end else if (ld_p2 && vld_p1) begin
      rsp_data_p2  <= {round_clamp(acc_s3[2]), round_clamp(acc_s3[1]), round_clamp(acc_s3[0])};
      rsp_phase_p2 <= k_p1;
    end
  end

  assign bus.rsp_valid     = vld_p2;
  assign bus.rsp_data      = rsp_data_p2;
  assign bus.rsp_phase     = rsp_phase_p2;
  assign bus.rsp_tile_last = (rsp_phase_p2 == 4'd15);

endmodule

// File: tb/tb_bicubic_interp.sv
// Bench for bicubic_interp: directed windows, a 2-D reference model and a
// per-cycle scoreboard on the response side.
module tb_bicubic_interp;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bicubic_interp_if bus();

  bicubic_interp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] data;
    logic [3:0]  phase;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [23:0] data;
    logic [3:0]  phase;
    logic        last;
  } out_t;

  exp_t        exp_q [$];
  out_t        out_log [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          model_k = 0;
  bit          lat_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_data;
  logic [3:0]  prev_phase;
  logic [23:0] win [16];
  int          wt [4][4] = '{'{-49, 987, 93, -7}, '{-75, 745, 399, -45},
                             '{-45, 399, 745, -75}, '{-7, 93, 987, -49}};

  assign bus.in_p1  = win[0];   assign bus.in_p2  = win[1];
  assign bus.in_p3  = win[2];   assign bus.in_p4  = win[3];
  assign bus.in_p5  = win[4];   assign bus.in_p6  = win[5];
  assign bus.in_p7  = win[6];   assign bus.in_p8  = win[7];
  assign bus.in_p9  = win[8];   assign bus.in_p10 = win[9];
  assign bus.in_p11 = win[10];  assign bus.in_p12 = win[11];
  assign bus.in_p13 = win[12];  assign bus.in_p14 = win[13];
  assign bus.in_p15 = win[14];  assign bus.in_p16 = win[15];

  // Full 2-D weighted sum per channel, rounded to nearest and clamped to 0..255.
  function automatic logic [23:0] model_pix(input logic [23:0] w [16], input int k);
    int          dx, dy;
    longint      acc, y;
    logic [23:0] r;
    dx = k % 4;
    dy = k / 4;
    r  = '0;
    for (int c = 0; c < 3; c++) begin
      acc = 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          acc += longint'(wt[dy][i] * wt[dx][j] * int'(w[4*i+j][8*c +: 8]));
      y = (acc + 64'sd524288) >>> 20;
      if (y < 0) y = 0;
      else if (y > 255) y = 255;
      r[8*c +: 8] = 8'(y);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_k    = 0;
      prev_stall = 1'b0;
    end else begin
      check("hsk_eq", 32'(bus.bcci_2_bf_hsked), 32'(bus.bf_req_valid & bus.bcci_req_ready));
      if (prev_stall) begin
        check("stall_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall_data",  32'(bus.rsp_data),  32'(prev_data));
        check("stall_phase", 32'(bus.rsp_phase), 32'(prev_phase));
      end
      if (bus.rsp_valid)
        check("tile_last", 32'(bus.rsp_tile_last), 32'(bus.rsp_phase == 4'd15));
      if (bus.rsp_valid && bus.rsp_ready) begin
        out_log.push_back('{bus.rsp_data, bus.rsp_phase, bus.rsp_tile_last});
        check("out_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_data",  32'(bus.rsp_data),  32'(e.data));
          check("sb_phase", 32'(bus.rsp_phase), 32'(e.phase));
          if (lat_en) check("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
      if (bus.bcci_2_bf_hsked) begin
        exp_q.push_back('{model_pix(win, model_k), 4'(model_k), cyc});
        model_k = (model_k + 1) % 16;
        check("in_flight", 32'(exp_q.size() <= 3), 32'd1);
      end
      prev_stall = bus.rsp_valid & ~bus.rsp_ready;
      prev_data  = bus.rsp_data;
      prev_phase = bus.rsp_phase;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.bf_req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic send(input int n, input bit gap);
    int got;
    got = 0;
    for (int g = 0; g < 4 * n + 20 && got < n; g++) begin
      bus.bf_req_valid = gap ? ((g % 2) == 0) : 1'b1;
      @(negedge clk);
      if (bus.bcci_2_bf_hsked) got++;
      @(posedge clk);
      #1;
    end
    bus.bf_req_valid = 1'b0;
    check("send_count", 32'(got), 32'(n));
  endtask

  task automatic set_win(input logic [23:0] v);
    for (int i = 0; i < 16; i++) win[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [23:0] tw [16];
    int          hs;

    bus.bf_req_valid = 1'b0;
    bus.rsp_ready    = 1'b1;
    set_win(24'h0);
    #1;
    check("rst_valid", 32'(bus.rsp_valid),     32'd0);
    check("rst_data",  32'(bus.rsp_data),      32'd0);
    check("rst_phase", 32'(bus.rsp_phase),     32'd0);
    check("rst_last",  32'(bus.rsp_tile_last), 32'd0);
    do_reset();

    // Pin the model against hand-computed pixels.
    for (int i = 0; i < 16; i++) tw[i] = 24'h0;
    tw[5] = 24'hFF0000;
    check("model_imp0",  32'(model_pix(tw, 0)),  32'h00ED0000);
    check("model_imp15", 32'(model_pix(tw, 15)), 32'h00020000);
    tw[5] = 24'h0;
    tw[4] = 24'hFFFFFF;
    check("model_neg",   32'(model_pix(tw, 0)),  32'h00000000);
    for (int i = 0; i < 16; i++) tw[i] = 24'h808080;
    check("model_flat",  32'(model_pix(tw, 7)),  32'h00808080);

    // Flat window
    lat_en = 1'b1;
    set_win(24'h808080);
    out_log.delete();
    send(16, 1'b0);
    repeat (6) step();
    check("flat_count", 32'(out_log.size()), 32'd16);
    if (out_log.size() == 16)
      for (int n = 0; n < 16; n++) begin
        check("flat_data",  32'(out_log[n].data),  32'h00808080);
        check("flat_phase", 32'(out_log[n].phase), 32'(n));
        check("flat_last",  32'(out_log[n].last),  32'(n == 15));
      end

    // Impulse in red at p[1][1]
    set_win(24'h0);
    win[5] = 24'hFF0000;
    out_log.delete();
    send(16, 1'b0);
    repeat (6) step();
    check("imp_count", 32'(out_log.size()), 32'd16);
    if (out_log.size() == 16) begin
      check("imp_ph0",  32'(out_log[0].data),  32'h00ED0000);
      check("imp_ph15", 32'(out_log[15].data), 32'h00020000);
    end

    // Negative lobe must clamp to zero
    set_win(24'h0);
    win[4] = 24'hFFFFFF;
    out_log.delete();
    send(16, 1'b0);
    repeat (6) step();
    check("neg_count", 32'(out_log.size()), 32'd16);
    if (out_log.size() == 16) check("neg_ph0", 32'(out_log[0].data), 32'h0);

    // Backpressure from reset
    do_reset();
    lat_en = 1'b0;
    for (int i = 0; i < 16; i++) win[i] = {8'(i * 37 + 5), 8'(i * 91), 8'(255 - i * 13)};
    out_log.delete();
    bus.rsp_ready    = 1'b0;
    bus.bf_req_valid = 1'b1;
    hs = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.bcci_2_bf_hsked) hs++;
      @(posedge clk);
      #1;
    end
    check("bp_hsk", 32'(hs), 32'd3);
    check("bp_ready", 32'(bus.bcci_req_ready), 32'd0);
    check("bp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    send(13, 1'b0);
    repeat (6) step();
    check("bp_count", 32'(out_log.size()), 32'd16);
    if (out_log.size() == 16)
      for (int n = 0; n < 16; n++) check("bp_phase", 32'(out_log[n].phase), 32'(n));

    // Gapped input
    do_reset();
    lat_en = 1'b1;
    out_log.delete();
    send(17, 1'b1);
    repeat (6) step();
    check("gap_count", 32'(out_log.size()), 32'd17);
    if (out_log.size() == 17)
      for (int n = 0; n < 17; n++) check("gap_phase", 32'(out_log[n].phase), 32'(n % 16));

    // Reset mid-tile
    do_reset();
    out_log.delete();
    send(7, 1'b0);
    check("mid_valid_pre", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_valid_rst", 32'(bus.rsp_valid), 32'd0);
    check("mid_phase_rst", 32'(bus.rsp_phase), 32'd0);
    step();
    rst_n = 1'b1;
    out_log.delete();
    send(4, 1'b0);
    repeat (6) step();
    check("mid_count", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) check("mid_first_phase", 32'(out_log[0].phase), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
